// File: rtl/wait_controller.sv
// Burst sequencer for the AXI-Stream wait datapath: fill RAM, hold one counter period, replay.
// Drives every datapath control line and the RAM address.
module wait_controller #(
    parameter int DEPTH = 16,
    parameter int ADR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_start,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic             waitDone,
    input  logic             m_ready,
    output logic             clear,
    output logic             ld,
    output logic             cntEn,
    output logic             s_ready,
    output logic             wr,
    output logic             rd,
    output logic [ADR_W-1:0] adr,
    output logic             m_valid,
    output logic             m_last,
    output logic             done
);

    localparam int LEN_W = ADR_W + 1;
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ld_d, done_d;
    logic             clear_q, ld_q, cnt_en_q, s_ready_q, rd_q, m_valid_q, m_last_q, done_q;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             m_last_d;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        ld_d     = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_start) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                    len_d    = '0;
                    ld_d     = 1'b1;
                end
            end
            FILL: begin
                if (s_valid) begin
                    wr_ptr_d = wr_ptr_q + ADR_W'(1);
                    len_d    = len_q + LEN_W'(1);
                    // s_last and the full-RAM beat collapse into one exit
                    if (s_last || (len_q == LEN_FULL)) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitDone) begin
                    state_d  = DRAIN;
                    rd_ptr_d = '0;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (m_last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so they register alongside the state
    always_comb begin
        adr_d    = '0;
        m_last_d = 1'b0;
        if (state_d == FILL) begin
            adr_d = wr_ptr_d;
        end else if (state_d == DRAIN) begin
            adr_d    = rd_ptr_d;
            m_last_d = ({1'b0, rd_ptr_d} == (len_d - LEN_W'(1)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            clear_q   <= 1'b1;
            ld_q      <= 1'b0;
            cnt_en_q  <= 1'b0;
            s_ready_q <= 1'b0;
            rd_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            adr_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            clear_q   <= (state_d == IDLE);
            ld_q      <= ld_d;
            cnt_en_q  <= (state_d == WAIT);
            s_ready_q <= (state_d == FILL);
            rd_q      <= (state_d == DRAIN);
            m_valid_q <= (state_d == DRAIN);
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            adr_q     <= adr_d;
        end
    end

    assign clear   = clear_q;
    assign ld      = ld_q;
    assign cntEn   = cnt_en_q;
    assign s_ready = s_ready_q;
    assign wr      = s_ready_q & s_valid;
    assign rd      = rd_q;
    assign adr     = adr_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign done    = done_q;

endmodule
